// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU request arbiter.
package fpu_arb_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OPCODE_W   = 3;
  localparam int unsigned FLAGS_W    = 5;
  localparam int unsigned FLAG_NV    = 4;
  localparam int unsigned WAIT_CNT_W = 8;

  localparam logic [DATA_W-1:0]  FPU_QNAN      = 32'h7FC0_0000;
  localparam logic [FLAGS_W-1:0] TIMEOUT_FLAGS = FLAGS_W'(1 << FLAG_NV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]   operand_a;
    logic [DATA_W-1:0]   operand_b;
    logic [OPCODE_W-1:0] opcode;
  } fpu_req_t;

endpackage

// File: rtl/fpu_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module fpu_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fpu_request_arbiter.sv
// Shares one FPU between the scalar core (req 0) and SIMD lanes, one op in flight.
// Optional WAIT-state timeout is enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_request_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_operand_a,
  input  logic [NUM_REQ*DATA_W-1:0]    req_operand_b,
  input  logic [NUM_REQ*OPCODE_W-1:0]  req_opcode,
  input  logic                         flush,
  output logic [DATA_W-1:0]            fpu_operand_a,
  output logic [DATA_W-1:0]            fpu_operand_b,
  output logic [OPCODE_W-1:0]          fpu_opcode,
  output logic                         fpu_doorbell,
  output logic                         simd_doorbell,
  output logic                         fpu_enable,
  input  logic                         fpu_done,
  input  logic [DATA_W-1:0]            fpu_result,
  input  logic [FLAGS_W-1:0]           fpu_flags,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_result,
  output logic [FLAGS_W-1:0]           rsp_flags,
  output logic                         rsp_error,
  output logic                         busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   hold_idx;
  fpu_req_t           hold_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  fpu_req_t           pick_req;

  fpu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  // Operand slice of the current winner, latched on accept.
  always_comb begin
    pick_req.operand_a = req_operand_a[32'(pick_idx)*DATA_W +: DATA_W];
    pick_req.operand_b = req_operand_b[32'(pick_idx)*DATA_W +: DATA_W];
    pick_req.opcode    = req_opcode[32'(pick_idx)*OPCODE_W +: OPCODE_W];
  end

  // Accept strobe is the only combinational output; muted by flush and reset.
  assign req_ready = (reset_n && (state == IDLE) && !flush) ? pick_grant : '0;

  assign fpu_operand_a = hold_q.operand_a;
  assign fpu_operand_b = hold_q.operand_b;
  assign fpu_opcode    = hold_q.opcode;

`ifdef FPU_ARB_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  rsp_error_q;
  assign rsp_error = rsp_error_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rsp_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      hold_idx      <= '0;
      hold_q        <= '0;
      fpu_doorbell  <= 1'b0;
      simd_doorbell <= 1'b0;
      fpu_enable    <= 1'b0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
      busy          <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      rsp_error_q   <= 1'b0;
`endif
    end else if (flush) begin
      // Abort without response; pointer and hold registers keep their values.
      state         <= IDLE;
      fpu_doorbell  <= 1'b0;
      simd_doorbell <= 1'b0;
      fpu_enable    <= 1'b0;
      rsp_valid     <= '0;
      busy          <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      rsp_error_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state         <= ISSUE;
            hold_q        <= pick_req;
            hold_idx      <= pick_idx;
            fpu_doorbell  <= (pick_idx == '0);
            simd_doorbell <= (pick_idx != '0);
            fpu_enable    <= 1'b1;
            busy          <= 1'b1;
          end
        end
        ISSUE: begin
          state         <= WAIT;
          fpu_doorbell  <= 1'b0;
          simd_doorbell <= 1'b0;
          fpu_enable    <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt      <= '0;
`endif
        end
        WAIT: begin
          if (fpu_done) begin
            state      <= RESP;
            rsp_valid  <= NUM_REQ'(1) << hold_idx;
            rsp_result <= fpu_result;
            rsp_flags  <= fpu_flags;
`ifdef FPU_ARB_TIMEOUT_EN
            rsp_error_q <= 1'b0;
          end else if (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES)) begin
            state       <= RESP;
            rsp_valid   <= NUM_REQ'(1) << hold_idx;
            rsp_result  <= FPU_QNAN;
            rsp_flags   <= TIMEOUT_FLAGS;
            rsp_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
`endif
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= '0;
          busy      <= 1'b0;
          rr_ptr    <= (hold_idx == IDX_W'(NUM_REQ-1)) ? '0 : hold_idx + IDX_W'(1);
`ifdef FPU_ARB_TIMEOUT_EN
          rsp_error_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
